// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: register index/data, the writeback request
// carried from the execution ports and the payload stored per source FIFO.
package wb_arbiter_pkg;

    localparam int REG_IDX_W     = 5;
    localparam int REG_DATA_W    = 32;
    localparam int WB_NUM_SRC    = 4;
    localparam int WB_FIFO_DEPTH = 2;

    typedef logic [REG_IDX_W-1:0]  reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_idx_t  dst;
        reg_data_t data;
    } wb_req_t;

    // Queued payload: a queued entry is valid by construction.
    typedef struct packed {
        reg_idx_t  dst;
        reg_data_t data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback FIFO: head is read combinationally, the count is
// exposed for ready generation and arbitration, flush empties it in one cycle.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int  FIFO_DEPTH = 2,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  wb_entry_t        i_push_data,
    input  logic             i_pop,
    output wb_entry_t        o_head,
    output logic [CNT_W-1:0] o_count
);

    wb_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign push_ok = i_push && (count_q < CNT_W'(FIFO_DEPTH)) && !i_flush;
    assign pop_ok  = i_pop && (count_q != '0) && !i_flush;
    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

    // Next pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers, cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents after reset are irrelevant because count is 0.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one small FIFO per execution-port source, drained
// round-robin onto the single register-file write / bypass broadcast port.
//
// Handshake: source s transfers in a cycle when i_req[s].valid && o_ready[s];
// a source seeing o_ready[s]=0 holds its request unchanged. o_ready depends
// only on registered FIFO occupancy. o_wb_req is a pure register output and
// carries valid=1 for exactly one cycle per drained entry.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int  NUM_SRC    = WB_NUM_SRC,
    parameter int  FIFO_DEPTH = WB_FIFO_DEPTH,
    localparam int IDX_W      = $clog2(NUM_SRC),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  wb_req_t            i_req [NUM_SRC],
    output logic [NUM_SRC-1:0] o_ready,
    output wb_req_t            o_wb_req
);

    logic [CNT_W-1:0]   fifo_count [NUM_SRC];
    wb_entry_t          fifo_head  [NUM_SRC];
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] nonempty;

    logic [IDX_W:0]     pick;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    wb_req_t            wb_q, wb_d;

    // Round-robin pick: first set bit at or after ptr, wrapping.
    // Returns {found, index}. Scanning backwards makes the last hit the winner.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_SRC;
            if (req[idx]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        wb_entry_t push_data;

        assign o_ready[s]  = fifo_count[s] < CNT_W'(FIFO_DEPTH);
        assign nonempty[s] = fifo_count[s] != '0;
        // Writes to x0 complete the handshake but are never queued.
        assign push[s]     = i_req[s].valid && o_ready[s]
                             && (i_req[s].dst != '0) && !i_flush;
        assign push_data   = '{dst: i_req[s].dst, data: i_req[s].data};

        wb_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_flush     (i_flush),
            .i_push      (push[s]),
            .i_push_data (push_data),
            .i_pop       (pop[s]),
            .o_head      (fifo_head[s]),
            .o_count     (fifo_count[s])
        );
    end

    assign pick      = rr_pick(nonempty, rr_ptr_q);
    assign grant_vld = pick[IDX_W];
    assign grant_idx = pick[IDX_W-1:0];
    assign o_wb_req  = wb_q;

    // Grant decode: pop the winning FIFO unless the pipeline is being flushed.
    always_comb begin
        pop = '0;
        if (grant_vld && !i_flush) pop[grant_idx] = 1'b1;
    end

    // Next round-robin pointer and next registered writeback.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wb_d       = wb_q;
        wb_d.valid = 1'b0;
        if (i_flush) begin
            rr_ptr_d = '0;
        end else if (grant_vld) begin
            rr_ptr_d   = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
            wb_d.valid = 1'b1;
            wb_d.dst   = fifo_head[grant_idx].dst;
            wb_d.data  = fifo_head[grant_idx].data;
        end
    end

    // Arbiter state and output register; reset clears the output to all zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
            wb_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wb_q     <= wb_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios, a queue-based reference model
// updated on every clock, and a negedge compare against that model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NUM_SRC = WB_NUM_SRC;
    localparam int DEPTH   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    wb_req_t            req [NUM_SRC];
    logic [NUM_SRC-1:0] o_ready;
    wb_req_t            o_wb_req;

    wb_arbiter #(.NUM_SRC(NUM_SRC), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_flush  (flush),
        .i_req    (req),
        .o_ready  (o_ready),
        .o_wb_req (o_wb_req)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic wb_req_t mk(input int d, input logic [31:0] v);
        wb_req_t r;
        r.valid = 1'b1;
        r.dst   = reg_idx_t'(d);
        r.data  = v;
        return r;
    endfunction

    // ---------------- reference model ----------------
    wb_req_t mq [NUM_SRC][$];
    int      rr_m = 0;
    wb_req_t exp_out = '0;
    bit      m_acc [NUM_SRC];
    int      m_g;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SRC; s++) mq[s].delete();
            rr_m    = 0;
            exp_out = '0;
        end else if (flush) begin
            for (int s = 0; s < NUM_SRC; s++) mq[s].delete();
            rr_m          = 0;
            exp_out.valid = 1'b0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++)
                m_acc[s] = req[s].valid && (mq[s].size() < DEPTH);
            m_g = -1;
            for (int k = 0; k < NUM_SRC; k++)
                if (m_g < 0 && mq[(rr_m + k) % NUM_SRC].size() > 0) m_g = (rr_m + k) % NUM_SRC;
            if (m_g >= 0) begin
                exp_out = mq[m_g].pop_front();
                rr_m    = (m_g + 1) % NUM_SRC;
            end else begin
                exp_out.valid = 1'b0;
            end
            for (int s = 0; s < NUM_SRC; s++)
                if (m_acc[s] && req[s].dst != 0) mq[s].push_back(req[s]);
        end
    end

    // ---------------- scoreboard compare ----------------
    logic [NUM_SRC-1:0] exp_rdy;
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            for (int s = 0; s < NUM_SRC; s++) exp_rdy[s] = mq[s].size() < DEPTH;
            check("model_wb", 64'(o_wb_req), 64'(exp_out));
            check("model_ready", 64'(o_ready), 64'(exp_rdy));
        end
    end

    // ---------------- driver ----------------
    wb_req_t pend [NUM_SRC][$];
    bit      pres_acc [NUM_SRC];
    logic [REG_IDX_W-1:0] seen_q [$];
    bit      saw_rdy0_low;

    // One cycle: at the negedge retire accepted requests, present the next ones.
    task automatic tick();
        @(negedge clk);
        for (int s = 0; s < NUM_SRC; s++)
            if (pres_acc[s] && pend[s].size() > 0) void'(pend[s].pop_front());
        for (int s = 0; s < NUM_SRC; s++) begin
            if (pend[s].size() > 0 && !rst) begin
                req[s]      = pend[s][0];
                pres_acc[s] = o_ready[s];
            end else begin
                req[s]      = '0;
                pres_acc[s] = 1'b0;
            end
        end
    endtask

    task automatic tick_log();
        tick();
        if (o_wb_req.valid) seen_q.push_back(o_wb_req.dst);
        if (!o_ready[0]) saw_rdy0_low = 1'b1;
    endtask

    function automatic bit idle();
        bit r;
        r = !exp_out.valid;
        for (int s = 0; s < NUM_SRC; s++)
            if (pend[s].size() != 0 || mq[s].size() != 0 || pres_acc[s]) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input string name, input int max_cyc);
        for (int k = 0; k < max_cyc && !idle(); k++) tick_log();
        check(name, 64'(idle()), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int s = 0; s < NUM_SRC; s++) begin
            req[s]      = '0;
            pres_acc[s] = 1'b0;
        end
        #1 rst = 1'b1;
        tick();
        tick();
        check("reset_wb", 64'(o_wb_req), 64'd0);
        check("reset_ready", 64'(o_ready), 64'hF);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // All four sources in the same cycle, rr_ptr=0: dst 1,2,3,4 in order.
        for (int s = 0; s < NUM_SRC; s++) pend[s].push_back(mk(s + 1, 32'h1000 + s));
        tick();
        tick(); check("all_c1_valid", 64'(o_wb_req.valid), 64'd0);
        tick(); check("all_c2", 64'(o_wb_req), 64'(mk(1, 32'h1000)));
        tick(); check("all_c3", 64'(o_wb_req), 64'(mk(2, 32'h1001)));
        tick(); check("all_c4", 64'(o_wb_req), 64'(mk(3, 32'h1002)));
        tick(); check("all_c5", 64'(o_wb_req), 64'(mk(4, 32'h1003)));
        tick(); check("all_c6_valid", 64'(o_wb_req.valid), 64'd0);
        drain("all_idle", 20);

        // Single source: 2-cycle latency, one cycle of valid.
        pend[1].push_back(mk(5, 32'hDEAD));
        tick();
        tick(); check("single_c1_valid", 64'(o_wb_req.valid), 64'd0);
        tick(); check("single_c2", 64'(o_wb_req), 64'(mk(5, 32'hDEAD)));
        tick(); check("single_c3_valid", 64'(o_wb_req.valid), 64'd0);
        drain("single_idle", 20);

        // x0 write discarded; following dst=7 emerges 2 cycles after acceptance.
        pend[2].push_back(mk(0, 32'h55));
        pend[2].push_back(mk(7, 32'h77));
        tick();
        tick(); check("x0_c1_valid", 64'(o_wb_req.valid), 64'd0);
        tick(); check("x0_c2_valid", 64'(o_wb_req.valid), 64'd0);
        tick(); check("x0_c3", 64'(o_wb_req), 64'(mk(7, 32'h77)));
        tick(); check("x0_c4_valid", 64'(o_wb_req.valid), 64'd0);
        drain("x0_idle", 20);

        // Back-pressure: source 0 streams while 1..3 hold requests.
        seen_q.delete();
        saw_rdy0_low = 1'b0;
        for (int i = 0; i < 4; i++) pend[0].push_back(mk(10 + i, 32'hA0 + i));
        for (int s = 1; s < NUM_SRC; s++) begin
            pend[s].push_back(mk(19 + s, 32'hB0 + s));
            pend[s].push_back(mk(22 + s, 32'hC0 + s));
        end
        drain("bp_idle", 60);
        check("bp_ready0_dropped", 64'(saw_rdy0_low), 64'd1);
        check("bp_total", 64'(seen_q.size()), 64'd10);
        begin
            logic [REG_IDX_W-1:0] got0 [$];
            foreach (seen_q[i]) if (seen_q[i] >= 10 && seen_q[i] <= 13) got0.push_back(seen_q[i]);
            check("bp_src0_count", 64'(got0.size()), 64'd4);
            for (int i = 0; i < 4 && i < got0.size(); i++)
                check("bp_src0_order", 64'(got0[i]), 64'(10 + i));
        end

        // Flush with three FIFOs loaded and a new request in the flush cycle.
        pend[0].push_back(mk(30, 32'h30));
        pend[1].push_back(mk(31, 32'h31));
        pend[2].push_back(mk(32, 32'h32));
        tick();
        pend[3].push_back(mk(33, 32'h33));
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", 64'(o_wb_req.valid), 64'd0);
        check("flush_ready", 64'(o_ready), 64'hF);
        seen_q.delete();
        for (int k = 0; k < 8; k++) tick_log();
        check("flush_nothing_emerges", 64'(seen_q.size()), 64'd0);
        drain("flush_idle", 10);

        // Asynchronous reset mid-burst.
        pend[1].push_back(mk(17, 32'h117));
        pend[2].push_back(mk(18, 32'h118));
        pend[3].push_back(mk(19, 32'h119));
        tick();
        tick();
        tick(); check("rst_pre", 64'(o_wb_req), 64'(mk(17, 32'h117)));
        #2 rst = 1'b1;
        #1 check("rst_immediate", 64'(o_wb_req), 64'd0);
        for (int s = 0; s < NUM_SRC; s++) begin
            pend[s].delete();
            pres_acc[s] = 1'b0;
            req[s]      = '0;
        end
        tick();
        rst = 1'b0;
        check("rst_ready", 64'(o_ready), 64'hF);
        pend[3].push_back(mk(9, 32'h99));
        pend[1].push_back(mk(8, 32'h88));
        tick();
        tick(); check("post_rst_c1_valid", 64'(o_wb_req.valid), 64'd0);
        tick(); check("post_rst_c2", 64'(o_wb_req), 64'(mk(8, 32'h88)));
        tick(); check("post_rst_c3", 64'(o_wb_req), 64'(mk(9, 32'h99)));
        drain("post_rst_idle", 20);

        tick();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
